pushbutton_conditioner: RTL and testbench
=========================================

// Module: pushbutton_conditioner
// PURPOSE
//   Input-side counterpart to the LED output path. Conditions the raw on-board pushbutton
//   into clean, single-clock events in the OSCH-derived domain (133 MHz nominal).
//   Chain: 2-flop synchroniser -> debounce/hold FSM.
//   Outputs: a debounced level, one-cycle press/release/long-press pulses and an 8-bit
//   short-press counter, all consumed by downstream counter/LED logic.
// PARAMETERS
//   ACTIVE_LEVEL       1'b0         raw level meaning "pressed" (board button is active-low)
//   DEBOUNCE_CYCLES    1_330_000    consecutive stable samples to qualify an edge (10 ms @133 MHz); >= 2
//   LONG_PRESS_CYCLES  133_000_000  cycles in HELD before long_press_pulse (1 s); > DEBOUNCE_CYCLES
//   CNT_W              32           width of qual/hold counters; must hold LONG_PRESS_CYCLES
// PORTS
//   clock             in   1  system clock (OSCH output)
//   reset_n           in   1  synchronous reset, active-low
//   button_raw        in   1  asynchronous raw pushbutton pin
//   pressed           out  1  debounced level, 1 = pressed
//   press_pulse       out  1  1-cycle strobe on a qualified press
//   release_pulse     out  1  1-cycle strobe on a qualified release
//   long_press_pulse  out  1  1-cycle strobe when a hold reaches LONG_PRESS_CYCLES
//   press_count       out  8  count of completed short presses; wraps 255 -> 0
// BEHAVIOUR
//   Reset (posedge clock, reset_n == 0): all outputs 0; FSM = IDLE; counters 0.
//     Both sync flops load ~ACTIVE_LEVEL (inactive). Reset overrides all other activity,
//     including mid-qualification and mid-hold. No pulse is emitted on reset entry or exit.
//   Sync: s1 <= button_raw; s2 <= s1. act = (s2 == ACTIVE_LEVEL). The FSM sees only act.
//   All outputs are registered. Pulses are high for exactly one cycle and never assert
//     in the same cycle as each other.
//   FSM states: IDLE, PRESS_QUAL, HELD, LONG_HELD, REL_QUAL.
//   IDLE:
//     act=1 -> PRESS_QUAL, qcnt = 1.
//   PRESS_QUAL:
//     act=0 -> IDLE (glitch rejected, no output change).
//     act=1 and qcnt == DEBOUNCE_CYCLES-1 -> HELD; pressed <= 1; press_pulse <= 1; hcnt = 0.
//     Otherwise qcnt++.
//   HELD:
//     hcnt++.
//     act=1 and hcnt == LONG_PRESS_CYCLES-1 -> LONG_HELD; long_press_pulse <= 1; long_flag = 1.
//     act=0 -> REL_QUAL, qcnt = 1; hcnt frozen.
//   LONG_HELD:
//     No counting.
//     act=0 -> REL_QUAL, qcnt = 1.
//   REL_QUAL:
//     act=1 -> back to HELD (long_flag = 0) or LONG_HELD (long_flag = 1); hcnt resumes.
//       No pulse is emitted.
//     act=0 and qcnt == DEBOUNCE_CYCLES-1 -> IDLE; pressed <= 0; release_pulse <= 1.
//       If long_flag = 0, press_count += 1 (mod 256). Clear long_flag.
//     Otherwise qcnt++.
//   Latency: if s1 first captures the active level at edge k and the input stays active,
//     press_pulse is high after edge k+DEBOUNCE_CYCLES+1. Release latency is symmetric.
//   long_press_pulse fires once per hold. Holding past it does not re-fire and does not
//     increment press_count.
//   A bounce shorter than DEBOUNCE_CYCLES samples never changes pressed or any pulse.
// TESTING
//   (bench params: ACTIVE_LEVEL=0, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
//   1. Reset: hold reset_n=0 for 3 clocks with button_raw=0 -> all outputs 0.
//      After release, no pulse until the input is qualified.
//   2. Clean press: button_raw 1->0 captured at edge k, held 10 cycles, then back to 1
//      -> press_pulse at k+5 only; pressed=1.
//      Release qualifies 5 edges after s1 sees 1 -> release_pulse; press_count=1.
//   3. Bounce: low-pulses of 1, 2 and 3 cycles separated by 2 high cycles
//      -> pressed stays 0, no pulses, press_count unchanged.
//   4. Long hold: press held 40 cycles -> press_pulse, then exactly one long_press_pulse
//      20 cycles after press_pulse. On release: release_pulse, press_count unchanged.
//   5. Release glitch: 2-cycle high glitch while HELD -> no release_pulse.
//      A long hold still fires at the original 20-cycle mark plus the 2 frozen cycles.
//   6. Wrap and mid-op reset: 256 short presses -> press_count returns to 0.
//      reset_n=0 while HELD -> pressed=0 next cycle and no release_pulse.

Source files
------------

// File: rtl/pushbutton_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser feeding a debounce/hold FSM.
// Produces a debounced level, one-cycle press/release/long-press strobes and a short-press count.
module pushbutton_conditioner #(
    parameter logic ACTIVE_LEVEL      = 1'b0,
    parameter int   DEBOUNCE_CYCLES   = 1_330_000,
    parameter int   LONG_PRESS_CYCLES = 133_000_000,
    parameter int   CNT_W             = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       button_raw,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_QUAL,
        HELD,
        LONG_HELD,
        REL_QUAL
    } state_t;

    localparam logic [CNT_W-1:0] QMAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HMAX = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_qcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_long_flag;
    logic             r_pressed;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_long_pulse;
    logic [7:0]       r_count;
    logic             w_act;

    assign w_act = (r_sync2 == ACTIVE_LEVEL);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1         <= ~ACTIVE_LEVEL;
            r_sync2         <= ~ACTIVE_LEVEL;
            r_state         <= IDLE;
            r_qcnt          <= '0;
            r_hcnt          <= '0;
            r_long_flag     <= 1'b0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_count         <= 8'd0;
        end else begin
            r_sync1         <= button_raw;
            r_sync2         <= r_sync1;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_act) begin
                        r_state <= PRESS_QUAL;
                        r_qcnt  <= ONE;
                    end
                end
                PRESS_QUAL: begin
                    if (!w_act) begin
                        r_state <= IDLE;
                    end else if (r_qcnt == QMAX) begin
                        r_state       <= HELD;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_hcnt        <= '0;
                    end else begin
                        r_qcnt <= r_qcnt + ONE;
                    end
                end
                HELD: begin
                    r_hcnt <= r_hcnt + ONE;
                    if (!w_act) begin
                        r_state <= REL_QUAL;
                        r_qcnt  <= ONE;
                    end else if (r_hcnt >= HMAX) begin
                        // >= so a hold counter frozen past the mark still fires on resume
                        r_state      <= LONG_HELD;
                        r_long_pulse <= 1'b1;
                        r_long_flag  <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (!w_act) begin
                        r_state <= REL_QUAL;
                        r_qcnt  <= ONE;
                    end
                end
                REL_QUAL: begin
                    if (w_act) begin
                        r_state <= r_long_flag ? LONG_HELD : HELD;
                    end else if (r_qcnt == QMAX) begin
                        r_state         <= IDLE;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                        r_long_flag     <= 1'b0;
                        if (!r_long_flag) begin
                            r_count <= r_count + 8'd1;
                        end
                    end else begin
                        r_qcnt <= r_qcnt + ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pressed          = r_pressed;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;
    assign press_count      = r_count;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Bench for pushbutton_conditioner: table of input segments with expected pulse
// positions and end state, plus wrap-around and mid-hold reset sequences.
module tb_pushbutton_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       button_raw;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    int pp_at, rp_at, lp_at, npulse, ovl;

    always #5 clk = ~clk;

    pushbutton_conditioner #(
        .ACTIVE_LEVEL(1'b0),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(20),
        .CNT_W(32)
    ) dut (
        .clock(clk),
        .reset_n(reset_n),
        .button_raw(button_raw),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_press_pulse(long_press_pulse),
        .press_count(press_count)
    );

    typedef struct {
        logic rst_n;
        logic raw;
        int   n;
        int   pp;
        int   rp;
        int   lp;
        logic prs;
        int   cnt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one input level for n clocks; record first index of each pulse.
    task automatic seg(input logic rst, input logic raw, input int n);
        reset_n    = rst;
        button_raw = raw;
        pp_at  = -1;
        rp_at  = -1;
        lp_at  = -1;
        npulse = 0;
        ovl    = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (press_pulse && pp_at < 0) pp_at = i;
            if (release_pulse && rp_at < 0) rp_at = i;
            if (long_press_pulse && lp_at < 0) lp_at = i;
            npulse += int'(press_pulse) + int'(release_pulse)
                    + int'(long_press_pulse);
            if (int'(press_pulse) + int'(release_pulse)
                + int'(long_press_pulse) > 1) ovl++;
        end
    endtask

    vec_t tv [18];

    initial begin
        reset_n    = 1'b0;
        button_raw = 1'b0;

        tv[0]  = '{1'b0, 1'b0,  3, -1, -1, -1, 1'b0, 0};
        tv[1]  = '{1'b1, 1'b0,  3, -1, -1, -1, 1'b0, 0};
        tv[2]  = '{1'b1, 1'b0,  5,  2, -1, -1, 1'b1, 0};
        tv[3]  = '{1'b1, 1'b1,  8, -1,  5, -1, 1'b0, 1};
        tv[4]  = '{1'b1, 1'b0,  1, -1, -1, -1, 1'b0, 1};
        tv[5]  = '{1'b1, 1'b1,  2, -1, -1, -1, 1'b0, 1};
        tv[6]  = '{1'b1, 1'b0,  2, -1, -1, -1, 1'b0, 1};
        tv[7]  = '{1'b1, 1'b1,  2, -1, -1, -1, 1'b0, 1};
        tv[8]  = '{1'b1, 1'b0,  3, -1, -1, -1, 1'b0, 1};
        tv[9]  = '{1'b1, 1'b1,  8, -1, -1, -1, 1'b0, 1};
        tv[10] = '{1'b1, 1'b0, 40,  5, -1, 25, 1'b1, 1};
        tv[11] = '{1'b1, 1'b1,  8, -1,  5, -1, 1'b0, 1};
        tv[12] = '{1'b1, 1'b0,  6,  5, -1, -1, 1'b1, 1};
        tv[13] = '{1'b1, 1'b1,  8, -1,  5, -1, 1'b0, 2};
        tv[14] = '{1'b1, 1'b0, 10,  5, -1, -1, 1'b1, 2};
        tv[15] = '{1'b1, 1'b1,  2, -1, -1, -1, 1'b1, 2};
        tv[16] = '{1'b1, 1'b0, 40, -1, -1, 15, 1'b1, 2};
        tv[17] = '{1'b1, 1'b1,  8, -1,  5, -1, 1'b0, 2};

        for (int k = 0; k < 18; k++) begin
            seg(tv[k].rst_n, tv[k].raw, tv[k].n);
            chk($sformatf("seg%0d press_at", k), pp_at, tv[k].pp);
            chk($sformatf("seg%0d release_at", k), rp_at, tv[k].rp);
            chk($sformatf("seg%0d long_at", k), lp_at, tv[k].lp);
            chk($sformatf("seg%0d pulses", k), npulse,
                int'(tv[k].pp >= 0) + int'(tv[k].rp >= 0)
                + int'(tv[k].lp >= 0));
            chk($sformatf("seg%0d overlap", k), ovl, 0);
            chk($sformatf("seg%0d pressed", k), int'(pressed),
                int'(tv[k].prs));
            chk($sformatf("seg%0d count", k), int'(press_count), tv[k].cnt);
        end

        // 254 more short presses: 2 -> 256 wraps to 0
        for (int p = 0; p < 254; p++) begin
            seg(1'b1, 1'b0, 6);
            chk($sformatf("wrap%0d press_at", p), pp_at, 5);
            seg(1'b1, 1'b1, 6);
            chk($sformatf("wrap%0d release_at", p), rp_at, 5);
            if (p == 252)
                chk("wrap count 255", int'(press_count), 255);
        end
        chk("wrap count 0", int'(press_count), 0);

        seg(1'b1, 1'b0, 6);
        seg(1'b1, 1'b1, 6);
        chk("pre-reset count", int'(press_count), 1);

        // reset while HELD
        seg(1'b1, 1'b0, 8);
        chk("held before reset", int'(pressed), 1);
        seg(1'b0, 1'b1, 1);
        chk("reset pressed", int'(pressed), 0);
        chk("reset count", int'(press_count), 0);
        chk("reset pulses", npulse, 0);
        seg(1'b1, 1'b1, 8);
        chk("post-reset pulses", npulse, 0);
        chk("post-reset pressed", int'(pressed), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
